// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter
package sram_arb_pkg;
  localparam int DATA_W = 16;
  localparam int BE_W = 2;
  localparam int NUM_PORTS = 2;
  localparam int CMD_ADDR_W = 20;
  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [BE_W-1:0]       be;
  } cmd_t;
endpackage

// File: rtl/sram_arb_priority.sv
// sram_arb_priority: fixed port-0 priority with a starvation escape for port 1
module sram_arb_priority
  import sram_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 arb_en,
  output logic [NUM_PORTS-1:0] gnt
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve;
  logic g1;
  assign g1 = arb_en && req1 && (!req0 || starve == SW'(MAX_STARVE));
  assign gnt = {g1, arb_en && req0 && !g1};
  always_ff @(posedge clk or posedge reset)
    if (reset) starve <= '0;
    else if (!req1 || g1) starve <= '0;
    else if (gnt[0]) starve <= starve + 1'b1;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and strobe sequencer for a 16-bit async SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [BE_W-1:0]   p0_be,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [BE_W-1:0]   p1_be,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic              busy
);
  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic cmd_we, port;
  logic [NUM_PORTS-1:0] gnt;
  cmd_t c0, c1, nxt;
  assign c0 = '{we: p0_we, addr: CMD_ADDR_W'(p0_addr), wdata: p0_wdata, be: p0_be};
  assign c1 = '{we: p1_we, addr: CMD_ADDR_W'(p1_addr), wdata: p1_wdata, be: p1_be};
  assign nxt = gnt[1] ? c1 : c0;
  assign busy = state != IDLE;
  // No grant in an ack cycle: the acked client still holds req, and waiting keeps port 0 priority intact.
  sram_arb_priority #(.MAX_STARVE(MAX_STARVE)) u_pri (
    .clk    (clk),
    .reset  (reset),
    .req0   (p0_req && !p0_ack),
    .req1   (p1_req && !p1_ack),
    .arb_en (state == IDLE && !p0_ack && !p1_ack),
    .gnt    (gnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cmd_we <= 1'b0;
      port <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 1'b1;
      sram_ub_n <= 1'b1;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          state <= ACCESS;
          cnt <= CNT_W'(1);
          cmd_we <= nxt.we;
          port <= gnt[1];
          sram_addr <= ADDR_W'(nxt.addr);
          sram_dq_out <= nxt.we ? nxt.wdata : sram_dq_out;
          sram_dq_oe <= nxt.we;
          sram_ce_n <= 1'b0;
          sram_oe_n <= nxt.we;
          sram_we_n <= !nxt.we;
          sram_lb_n <= nxt.we ? !nxt.be[0] : 1'b0;
          sram_ub_n <= nxt.we ? !nxt.be[1] : 1'b0;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          // Release we_n one cycle early so data is held past the strobe.
          if (cmd_we && cnt == CNT_W'(ACCESS_CYCLES - 1)) sram_we_n <= 1'b1;
          if (cnt == CNT_W'(ACCESS_CYCLES)) begin
            state <= cmd_we ? TURN : IDLE;
            p0_ack <= !port;
            p1_ack <= port;
            p0_rdata <= (!cmd_we && !port) ? sram_dq_in : p0_rdata;
            p1_rdata <= (!cmd_we && port) ? sram_dq_in : p1_rdata;
            sram_dq_oe <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of arbitration, strobe timing and reset
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [19:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic [1:0] p0_be = '0, p1_be = '0;
  logic p0_ack, p1_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, busy;
  logic [15:0] p0_rdata, p1_rdata, sram_dq_out, sram_dq_in;
  logic [19:0] sram_addr;
  logic [15:0] mem [16];
  logic [8:0] ctl;
  logic inv_en = 1'b0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n), .busy(busy)
  );
  assign ctl = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy, p0_ack, p1_ack};
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[3:0]] : 16'h0000;
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[2] <= 16'hBEEF;
      mem[15] <= 16'hAAAA;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[3:0]][7:0] <= sram_dq_out[7:0];
      if (!sram_ub_n) mem[sram_addr[3:0]][15:8] <= sram_dq_out[15:8];
    end
  always @(negedge clk)
    if (inv_en) begin
      total++;
      if (sram_dq_oe && !sram_oe_n) $display("FAIL bus_contention dq_oe=%b oe_n=%b", sram_dq_oe, sram_oe_n);
      else passed++;
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick;
    tick;
    total++;
    if ({ctl, sram_addr, sram_dq_out, p0_rdata, p1_rdata} !== {9'b111110000, 20'h0, 48'h0})
      $display("FAIL reset_values ctl=%b addr=%h dq_out=%h", ctl, sram_addr, sram_dq_out);
    else passed++;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      total++;
      if (ctl !== 9'b111110000) $display("FAIL idle_no_req cycle %0d ctl=%b exp=111110000", c, ctl);
      else passed++;
    end
  endtask
  task automatic test_p1_read;
    p1_we = 0; p1_addr = 20'h00012; p1_req = 1;
    for (int c = 1; c <= 2; c++) begin
      tick;
      total++;
      if ({ctl, sram_addr} !== {9'b001000100, 20'h00012})
        $display("FAIL p1_read_pins cycle %0d ctl=%b addr=%h exp=001000100 00012", c, ctl, sram_addr);
      else passed++;
    end
    tick;
    p1_req = 0;
    total++;
    if ({ctl, p1_rdata} !== {9'b111110001, 16'hBEEF})
      $display("FAIL p1_read_ack ctl=%b rdata=%h exp=111110001 beef", ctl, p1_rdata);
    else passed++;
    tick;
    total++;
    if (ctl !== 9'b111110000) $display("FAIL p1_read_single_ack ctl=%b exp=111110000", ctl);
    else passed++;
  endtask
  task automatic test_p0_write;
    p0_we = 1; p0_addr = 20'hFFFFF; p0_wdata = 16'h1234; p0_be = 2'b01; p0_req = 1;
    tick;
    total++;
    if ({ctl, sram_addr, sram_dq_out} !== {9'b010011100, 20'hFFFFF, 16'h1234})
      $display("FAIL p0_write_c1 ctl=%b addr=%h dq=%h exp=010011100 fffff 1234", ctl, sram_addr, sram_dq_out);
    else passed++;
    tick;
    total++;
    if ({ctl, sram_dq_out} !== {9'b011011100, 16'h1234})
      $display("FAIL p0_write_c2 ctl=%b dq=%h exp=011011100 1234", ctl, sram_dq_out);
    else passed++;
    tick;
    p0_req = 0;
    total++;
    if (ctl !== 9'b111110110) $display("FAIL p0_write_turn_ack ctl=%b exp=111110110", ctl);
    else passed++;
    tick;
    total++;
    if (ctl !== 9'b111110000) $display("FAIL p0_write_idle ctl=%b exp=111110000", ctl);
    else passed++;
    total++;
    if (mem[15] !== 16'hAA34) $display("FAIL p0_write_bytes mem=%h exp=aa34", mem[15]);
    else passed++;
  endtask
  task automatic test_starve;
    int seq_n = 0;
    logic prev0 = 0, prev1 = 0;
    p0_we = 0; p0_addr = 20'h3; p1_we = 0; p1_addr = 20'h4;
    p0_req = 1; p1_req = 1;
    for (int c = 0; c < 100 && seq_n < 10; c++) begin
      tick;
      total++;
      if ((p0_ack && prev0) || (p1_ack && prev1) || (p0_ack && p1_ack))
        $display("FAIL ack_pulse cycle %0d p0_ack=%b p1_ack=%b prev=%b%b", c, p0_ack, p1_ack, prev0, prev1);
      else passed++;
      if (p0_ack || p1_ack) begin
        total++;
        if (p1_ack !== (seq_n % 5 == 4)) $display("FAIL grant_order #%0d p1_ack=%b exp=%b", seq_n, p1_ack, seq_n % 5 == 4);
        else passed++;
        seq_n++;
        if (seq_n == 10) begin p0_req = 0; p1_req = 0; end
      end
      prev0 = p0_ack; prev1 = p1_ack;
    end
    total++;
    if (seq_n != 10) $display("FAIL starve_timeout grants=%0d exp=10", seq_n);
    else passed++;
    tick;
    total++;
    if ({ctl, p0_rdata, p1_rdata} !== {9'b111110000, 16'h1003, 16'h1004})
      $display("FAIL starve_end ctl=%b r0=%h r1=%h exp=111110000 1003 1004", ctl, p0_rdata, p1_rdata);
    else passed++;
  endtask
  task automatic test_back_to_back;
    p1_we = 1; p1_addr = 20'h5; p1_wdata = 16'h5555; p1_be = 2'b11; p1_req = 1;
    tick;
    total++;
    if (ctl !== 9'b010001100) $display("FAIL b2b_write_c1 ctl=%b exp=010001100", ctl);
    else passed++;
    tick;
    tick;
    p1_we = 0;
    total++;
    if (ctl !== 9'b111110101) $display("FAIL b2b_turn ctl=%b exp=111110101", ctl);
    else passed++;
    tick;
    total++;
    if (ctl !== 9'b111110000) $display("FAIL b2b_after_turn ctl=%b exp=111110000", ctl);
    else passed++;
    tick;
    total++;
    if ({ctl, sram_addr} !== {9'b001000100, 20'h5}) $display("FAIL b2b_read_c1 ctl=%b addr=%h exp=001000100 00005", ctl, sram_addr);
    else passed++;
    tick;
    tick;
    p1_req = 0;
    total++;
    if ({ctl, p1_rdata} !== {9'b111110001, 16'h5555}) $display("FAIL b2b_read_ack ctl=%b rdata=%h exp=111110001 5555", ctl, p1_rdata);
    else passed++;
    tick;
  endtask
  task automatic test_reset_midway;
    int lat = 0;
    p0_we = 1; p0_addr = 20'h6; p0_wdata = 16'h6666; p0_be = 2'b11; p0_req = 1;
    tick;
    total++;
    if (ctl !== 9'b010001100) $display("FAIL mid_write_c1 ctl=%b exp=010001100", ctl);
    else passed++;
    inv_en = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({ctl, sram_addr, sram_dq_out, p0_rdata} !== {9'b111110000, 20'h0, 16'h0, 16'h0})
      $display("FAIL mid_reset_async ctl=%b addr=%h dq=%h r0=%h", ctl, sram_addr, sram_dq_out, p0_rdata);
    else passed++;
    tick;
    total++;
    if (ctl !== 9'b111110000) $display("FAIL mid_reset_no_ack ctl=%b exp=111110000", ctl);
    else passed++;
    reset = 1'b0;
    inv_en = 1'b1;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      tick;
      if (p0_ack) lat = c;
    end
    p0_req = 0;
    total++;
    if (lat != 3) $display("FAIL mid_reissue_latency got %0d exp 3", lat);
    else passed++;
    tick;
    total++;
    if (mem[6] !== 16'h6666) $display("FAIL mid_reissue_data mem=%h exp=6666", mem[6]);
    else passed++;
  endtask
  initial begin
    test_reset;
    inv_en = 1'b1;
    test_p1_read;
    test_p0_write;
    test_starve;
    test_back_to_back;
    test_reset_midway;
    inv_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
